// File: rtl/mips_arb_pkg.sv
// mips_arb_pkg
// Shared types for the MIPS unified-memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, IFETCH, DATA, DONE)
//   GNT_*       : grant encoding produced by the fixed-priority selector
//   arb_grant   : fixed-priority selector (data before fetch)
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    // Data accesses win over fetches so a load/store of the current
    // instruction always retires before the next instruction is fetched.
    function automatic logic [1:0] arb_grant(input logic if_req, input logic d_req);
        logic [1:0] gnt;
        if (d_req) begin
            gnt = GNT_D;
        end else if (if_req) begin
            gnt = GNT_IF;
        end else begin
            gnt = GNT_NONE;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mips_arb_timer.sv
// mips_arb_timer
// Watchdog for an outstanding memory request. Only built when the
// MEM_TIMEOUT_EN macro is defined.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : zero the count (held while no transaction is outstanding)
//   en       : count one cycle of waiting for mem_ack
//   expire   : TIMEOUT cycles of waiting have elapsed (this is the last one)
`ifdef MEM_TIMEOUT_EN
module mips_arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count is zero on the first waiting cycle, so the TIMEOUT-th
    // waiting cycle is the one where count_q reaches TIMEOUT-1.
    assign expire = en & (count_q == CW'(TIMEOUT - 1));

    // Next count: clear, advance while waiting, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CW{1'b0}};
        end else if (en && !expire) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares one single-ported memory between the MIPS instruction-fetch port
// and data port. Accesses are serialised with a req/ack handshake toward
// memory; a combinational stall holds the core until every access it has
// requested has completed. Data has fixed priority over fetch.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   if_req/if_addr         : fetch request (held until if_valid) and address
//   if_rdata/if_valid      : registered fetched word, one-cycle done pulse
//   d_read/d_write         : data request (held until d_valid); both = write
//   d_addr/d_wdata         : data address and store data
//   d_rdata/d_valid        : registered load data, one-cycle done pulse
//   mem_req/mem_we         : memory request (held until mem_ack), write enable
//   mem_addr/mem_wdata     : memory address / write data, stable during mem_req
//   mem_rdata/mem_ack      : memory read data, one-cycle completion
//   stall                  : freeze core PC / register writes
//   mem_err                : sticky timeout flag
//
// Optional feature: define MEM_TIMEOUT_EN to abandon a request after TIMEOUT
// cycles without mem_ack (valid pulse with zero data, sticky mem_err).
// Without it the arbiter waits indefinitely and mem_err stays 0.
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          mem_err
);

    arb_state_e    state_q,     state_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] d_rdata_q,   d_rdata_d;
    logic          if_valid_q,  if_valid_d;
    logic          d_valid_q,   d_valid_d;
    logic          mem_err_q,   mem_err_d;

    logic          d_req_s;
    logic [1:0]    gnt_s;
    logic          busy_s;
    logic          timeout_s;

    assign d_req_s = d_read | d_write;
    assign gnt_s   = arb_grant(if_req, d_req_s);
    assign busy_s  = (state_q == IFETCH) || (state_q == DATA);

`ifdef MEM_TIMEOUT_EN
    logic tmr_expire_s;

    mips_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (~busy_s),
        .en     (busy_s),
        .expire (tmr_expire_s)
    );

    assign timeout_s = tmr_expire_s;
`else
    assign timeout_s = 1'b0;
`endif

    // Arbitration, handshake sequencing and result capture.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        mem_err_d   = mem_err_q;

        case (state_q)
            IDLE: begin
                case (gnt_s)
                    GNT_D: begin
                        state_d     = DATA;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_write;   // read+write counts as a write
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end
                    GNT_IF: begin
                        state_d     = IFETCH;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = {DW{1'b0}};
                    end
                    default: begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                endcase
            end
            IFETCH: begin
                // An ack on the timeout cycle is a normal completion.
                if (mem_ack) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                end else if (timeout_s) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_rdata_d = {DW{1'b0}};
                    if_valid_d = 1'b1;
                    mem_err_d  = 1'b1;
                end else begin
                    mem_req_d  = 1'b1;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_valid_d = 1'b1;
                    // Stores leave the last load result in place.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else if (timeout_s) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_rdata_d = {DW{1'b0}};
                    d_valid_d = 1'b1;
                    mem_err_d = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            DONE: begin
                // Bubble cycle: the requester sees its valid and drops or
                // changes its request before the next arbitration.
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            if_rdata_q  <= {DW{1'b0}};
            d_rdata_q   <= {DW{1'b0}};
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign mem_err   = mem_err_q;

    // The core is held while any of its requests is still outstanding.
    assign stall = (if_req & ~if_valid_q) | (d_req_s & ~d_valid_q);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter
// Randomised bench for mips_mem_arbiter (default build, no timeout feature).
// A memory responder with random ack latency and stray acks serves mem_req;
// the core side issues instructions with fetch and/or data accesses and
// checks results against a reference memory kept as an associative array.
module tb_mips_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall;
    logic          mem_err;

    always #5 clk = ~clk;

    mips_mem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .mem_err   (mem_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Initial memory contents: distinct per word address.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] mem_arr [logic [31:0]];   // memory responder storage
    logic [31:0] ref_mem [logic [31:0]];   // reference model of memory

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // ---------------- memory responder ----------------
    logic [32:0] grant_q [$];     // {we, addr} of every completed access
    int          last_delay = 0;
    int          resp_cnt   = 0;
    bit          resp_busy  = 1'b0;
    bit          ack_real   = 1'b0;
    bit          prev_real  = 1'b0;
    bit          hold_ack   = 1'b0;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_we;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    end

    always @(negedge clk) begin
        prev_real = ack_real;
        ack_real  = 1'b0;
        mem_ack   = 1'b0;
        if (rst) begin
            resp_busy = 1'b0;
        end else if (prev_real) begin
            check_eq("req_drop_after_ack", 32'(mem_req), 32'h0);
            resp_busy = 1'b0;
        end else if (mem_req) begin
            if (!resp_busy) begin
                resp_busy  = 1'b1;
                lat_addr   = mem_addr;
                lat_we     = mem_we;
                lat_wdata  = mem_wdata;
                resp_cnt   = $urandom_range(0, 3);
                last_delay = resp_cnt;
            end else begin
                check_eq("addr_stable", mem_addr, lat_addr);
                check_eq("we_stable", 32'(mem_we), 32'(lat_we));
                if (lat_we) check_eq("wdata_stable", mem_wdata, lat_wdata);
            end
            if (!hold_ack) begin
                if (resp_cnt == 0) begin
                    mem_ack   = 1'b1;
                    ack_real  = 1'b1;
                    mem_rdata = mem_rd(mem_addr);
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    grant_q.push_back({mem_we, mem_addr});
                end else begin
                    resp_cnt--;
                end
            end
        end else if ($urandom_range(0, 3) == 0) begin
            // Stray ack while idle: must be ignored.
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
        end
    end

    // ---------------- core side ----------------
    logic [31:0] last_rdata = 32'h0;   // expected d_rdata after any access

    task automatic run_instr(input bit f, input bit rd, input bit wr,
                             input logic [31:0] fa, input logic [31:0] da,
                             input logic [31:0] wd);
        bit          has_d, single, f_done, d_done, exp_stall;
        int          cyc;
        logic [31:0] exp_if, exp_d;
        has_d  = rd | wr;
        single = f ^ has_d;
        @(negedge clk);
        grant_q.delete();
        exp_if  = ref_rd(fa);
        if_req  = f;
        if_addr = fa;
        d_read  = rd;
        d_write = wr;
        d_addr  = da;
        d_wdata = wd;
        f_done  = !f;
        d_done  = !has_d;
        cyc     = 0;
        while (!(f_done && d_done) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            exp_stall = (if_req && !if_valid) || ((d_read || d_write) && !d_valid);
            check_eq("stall", 32'(stall), 32'(exp_stall));
            if (if_valid) begin
                if (f_done) begin
                    check_eq("if_valid_extra", 32'(if_valid), 32'h0);
                end else begin
                    check_eq("if_rdata", if_rdata, exp_if);
                    check_eq("bubble_if", 32'(mem_req), 32'h0);
                    if (has_d) check_eq("data_before_fetch", 32'(d_done), 32'h1);
                    if (single) check_eq("if_latency", 32'(cyc), 32'(2 + last_delay));
                    if_req = 1'b0;
                    f_done = 1'b1;
                end
            end
            if (d_valid) begin
                if (d_done) begin
                    check_eq("d_valid_extra", 32'(d_valid), 32'h0);
                end else begin
                    if (wr) begin
                        check_eq("d_rdata_kept_on_store", d_rdata, last_rdata);
                        ref_mem[da] = wd;
                    end else begin
                        exp_d = ref_rd(da);
                        check_eq("d_rdata", d_rdata, exp_d);
                        last_rdata = exp_d;
                    end
                    check_eq("bubble_d", 32'(mem_req), 32'h0);
                    if (single) check_eq("d_latency", 32'(cyc), 32'(2 + last_delay));
                    d_read  = 1'b0;
                    d_write = 1'b0;
                    d_done  = 1'b1;
                end
            end
        end
        check_eq("instr_done", 32'(f_done && d_done), 32'h1);
        if_req  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        check_eq("grant_count", 32'(grant_q.size()), 32'(int'(f) + int'(has_d)));
        if (has_d && grant_q.size() >= 1) begin
            check_eq("d_grant_addr", grant_q[0][31:0], da);
            check_eq("d_grant_we", 32'(grant_q[0][32]), 32'(wr));
        end
        if (f && grant_q.size() >= (has_d ? 2 : 1)) begin
            check_eq("if_grant_addr", grant_q[has_d ? 1 : 0][31:0], fa);
            check_eq("if_grant_we", 32'(grant_q[has_d ? 1 : 0][32]), 32'h0);
        end
    endtask

    task automatic reset_mid_txn();
        int cyc;
        @(negedge clk);
        hold_ack = 1'b1;
        d_read   = 1'b1;
        d_addr   = 32'h1001_0008;
        cyc      = 0;
        while (!mem_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_req_seen", 32'(mem_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_req_drop", 32'(mem_req), 32'h0);
        check_eq("rst_no_valid", 32'(d_valid), 32'h0);
        rst      = 1'b0;
        d_read   = 1'b0;
        hold_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_after_valid", 32'(d_valid), 32'h0);
            check_eq("rst_after_req", 32'(mem_req), 32'h0);
        end
        check_eq("rst_d_rdata", d_rdata, 32'h0);
        last_rdata = 32'h0;
    endtask

    initial begin
        bit          f, rd, wr;
        int          dop;
        logic [31:0] fa, da;
        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_read  = 1'b0;
        d_write = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        mem_arr[32'h0040_0000] = 32'h8C08_0004;
        ref_mem[32'h0040_0000] = 32'h8C08_0004;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req", 32'(mem_req), 32'h0);
        check_eq("rst_mem_we", 32'(mem_we), 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_if_rdata", if_rdata, 32'h0);
        check_eq("rst_d_rdata0", d_rdata, 32'h0);
        check_eq("rst_if_valid", 32'(if_valid), 32'h0);
        check_eq("rst_d_valid", 32'(d_valid), 32'h0);
        check_eq("rst_mem_err", 32'(mem_err), 32'h0);
        check_eq("rst_stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // Directed: fetch only, simultaneous fetch+load, store, read+write.
        run_instr(1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h0);
        check_eq("first_fetch_word", if_rdata, 32'h8C08_0004);
        run_instr(1'b1, 1'b1, 1'b0, 32'h0040_0004, 32'h1001_0000, 32'h0);
        run_instr(1'b0, 1'b0, 1'b1, 32'h0, 32'h1001_0004, 32'hDEAD_BEEF);
        run_instr(1'b0, 1'b1, 1'b1, 32'h0, 32'h1001_0000, 32'h0BAD_F00D);
        run_instr(1'b0, 1'b1, 1'b0, 32'h0, 32'h1001_0004, 32'h0);
        check_eq("load_after_store", d_rdata, 32'hDEAD_BEEF);

        reset_mid_txn();

        // Randomised instruction stream.
        for (int i = 0; i < 80; i++) begin
            f   = 1'($urandom_range(0, 1));
            dop = $urandom_range(0, 3);
            if (!f && dop == 0) f = 1'b1;
            rd  = (dop == 1) || (dop == 3);
            wr  = (dop >= 2);
            fa  = 32'h0040_0000 + (32'($urandom_range(0, 15)) << 2);
            da  = 32'h1001_0000 + (32'($urandom_range(0, 7)) << 2);
            run_instr(f, rd, wr, fa, da, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_eq("idle_stall", 32'(stall), 32'h0);
            end
        end

        check_eq("mem_err_default", 32'(mem_err), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Shares one single-ported unified memory between the MIPS core's instruction-fetch port (InstAdd/Inst) and data port (MemAdd/WriteData/MemRead/MemWrite/MemReadData).
- Sits between the MIPS top level and the memory model.
- Serialises accesses with a req/ack handshake toward memory.
- Drives a stall back to the core until both the fetch and the data access of the current instruction have completed.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 15, max cycles waiting for mem_ack (used only with the optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  instruction fetch request, held until if_valid
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched instruction, registered
if_valid  out  1  one-cycle pulse, fetch complete
d_read  in  1  data read request, held until d_valid
d_write  in  1  data write request, held until d_valid
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, registered
d_valid  out  1  one-cycle pulse, data access complete
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write enable, stable while mem_req
mem_addr  out  AW  memory address, stable while mem_req
mem_wdata  out  DW  memory write data, stable while mem_req
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
stall  out  1  freeze core PC/register writes
mem_err  out  1  timeout flag (optional feature only; otherwise tied 0)

Behaviour:
Interface decision: one clock, clk; reset rst is synchronous, active-high.

Reset values:
- state=IDLE.
- mem_req, mem_we, if_valid, d_valid, mem_err = 0.
- mem_addr, mem_wdata, if_rdata, d_rdata = 0.

States: IDLE, IFETCH, DATA, DONE.

IDLE:
- Data request pending (d_read|d_write) -> DATA. Data has fixed priority over fetch.
- Else if_req -> IFETCH.
- Else stay.
- Address, write data and mem_we are latched on the transition. mem_req rises the next cycle, registered.

IFETCH/DATA:
- mem_req=1 until mem_ack.
- On the mem_ack cycle: capture mem_rdata into if_rdata or d_rdata, pulse the matching valid next cycle, go to DONE.
- d_rdata is updated on reads only; writes leave it unchanged.

DONE:
- One bubble cycle, then -> IDLE.
- Guarantees the requester has dropped or changed its request before re-arbitration.

Latency: minimum 3 cycles from request to valid with a same-cycle ack (IDLE→X, X with ack, DONE/valid).

Conflict and boundary rules:
- d_read & d_write both high: treated as a write.
- Request withdrawn mid-transaction: the transaction still completes; the valid pulse is still issued; the requester ignores it.
- mem_ack while in IDLE/DONE: ignored.
- Reset mid-transaction: immediate return to IDLE, mem_req drops, transaction abandoned, no valid pulse.

stall (combinational) = (if_req & ~if_valid) | ((d_read|d_write) & ~d_valid).

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter runs in IFETCH/DATA and is cleared on state entry. If TIMEOUT cycles elapse without mem_ack:
  - drop mem_req;
  - set sticky mem_err (cleared only by rst);
  - pulse the matching valid with rdata=0;
  - go to DONE.
  - A mem_ack arriving on the same cycle as the timeout wins (normal completion, no error).
- Undefined: no counter; the arbiter waits indefinitely and mem_err is constant 0.

Decomposition:
- Package mips_arb_pkg: state enum (IDLE, IFETCH, DATA, DONE) and the grant encoding constants GNT_NONE, GNT_IF, GNT_D.
- One sub-module is natural: mips_arb_timer (load/clear, count, expire), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00400000, ack on 2nd cycle of mem_req with rdata=0x8C080004 -> if_rdata=0x8C080004, one if_valid pulse, stall deasserts the same cycle.
- Simultaneous: if_req and d_read at addr 0x10010000 -> data granted first (mem_addr=0x10010000), fetch next; stall stays high until both valids have been seen.
- Store: d_write, d_addr=0x10010004, d_wdata=0xDEADBEEF -> mem_we=1 with addr/data stable for the whole mem_req; d_rdata unchanged.
- Read+write both high -> mem_we=1; bubble check: after any valid, mem_req stays low for at least 1 cycle.
- Reset asserted while mem_req=1 -> next cycle mem_req=0, state IDLE, no valid pulse.
- MEM_TIMEOUT_EN, TIMEOUT=15, no ack -> mem_req drops after 15 cycles; mem_err=1 and stays high; d_valid pulses with d_rdata=0.
